// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA timing from CLOCK_50: pixel counters, renderer coordinate publish,
// sync/blank delay-matched to the renderer pipeline, and registered DAC pin drive.
module vga_timing_gen #(
  parameter int PIPE_DEPTH = 2
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       req,
  output logic       frame_start,
  output logic       vblank_start,
  input  logic [7:0] r_in,
  input  logic [7:0] g_in,
  input  logic [7:0] b_in,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic       VGA_CLK
);

  localparam logic [9:0] H_VISIBLE    = 10'd640;
  localparam logic [9:0] H_SYNC_FIRST = 10'd656;
  localparam logic [9:0] H_SYNC_LAST  = 10'd751;
  localparam logic [9:0] H_LAST       = 10'd799;
  localparam logic [9:0] V_VISIBLE    = 10'd480;
  localparam logic [9:0] V_SYNC_FIRST = 10'd490;
  localparam logic [9:0] V_SYNC_LAST  = 10'd491;
  localparam logic [9:0] V_LAST       = 10'd524;

  logic       r_phase;
  logic [9:0] r_h_cnt;
  logic [9:0] r_v_cnt;
  logic       r_frame_start;
  logic       r_vblank_start;
  logic       r_hs;
  logic       r_vs;
  logic       r_blank_n;
  logic [7:0] r_red;
  logic [7:0] r_grn;
  logic [7:0] r_blu;

  logic       w_pix_en;
  logic       w_h_last;
  logic       w_v_last;
  logic       w_visible;
  logic [2:0] w_raw;  // {hs, vs, blank_n}
  logic [2:0] w_dly;

  assign w_pix_en  = r_phase;
  assign w_h_last  = (r_h_cnt == H_LAST);
  assign w_v_last  = (r_v_cnt == V_LAST);
  assign w_visible = (r_h_cnt < H_VISIBLE) && (r_v_cnt < V_VISIBLE);

  assign w_raw[2] = ~((r_h_cnt >= H_SYNC_FIRST) && (r_h_cnt <= H_SYNC_LAST));
  assign w_raw[1] = ~((r_v_cnt >= V_SYNC_FIRST) && (r_v_cnt <= V_SYNC_LAST));
  assign w_raw[0] = w_visible;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_phase        <= 1'b0;
      r_h_cnt        <= 10'd0;
      r_v_cnt        <= 10'd0;
      r_frame_start  <= 1'b0;
      r_vblank_start <= 1'b0;
    end else begin
      r_phase        <= ~r_phase;
      r_frame_start  <= w_pix_en && w_h_last && w_v_last;
      r_vblank_start <= w_pix_en && w_h_last && (r_v_cnt == V_VISIBLE - 10'd1);
      if (w_pix_en) begin
        if (w_h_last) begin
          r_h_cnt <= 10'd0;
          r_v_cnt <= w_v_last ? 10'd0 : r_v_cnt + 10'd1;
        end else begin
          r_h_cnt <= r_h_cnt + 10'd1;
        end
      end
    end
  end

  // Sync/blank ride a shift register matching the renderer's colour latency.
  generate
    if (PIPE_DEPTH == 0) begin : g_no_pipe
      assign w_dly = w_raw;
    end else begin : g_pipe
      logic [2:0] r_pipe [PIPE_DEPTH];
      always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < PIPE_DEPTH; i++) r_pipe[i] <= 3'b110;
        end else if (w_pix_en) begin
          r_pipe[0] <= w_raw;
          for (int i = 1; i < PIPE_DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
        end
      end
      assign w_dly = r_pipe[PIPE_DEPTH-1];
    end
  endgenerate

  // Updates land on the VGA_CLK falling edge, giving the DAC a full half-period of setup.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_hs      <= 1'b1;
      r_vs      <= 1'b1;
      r_blank_n <= 1'b0;
      r_red     <= 8'd0;
      r_grn     <= 8'd0;
      r_blu     <= 8'd0;
    end else if (w_pix_en) begin
      r_hs      <= w_dly[2];
      r_vs      <= w_dly[1];
      r_blank_n <= w_dly[0];
      r_red     <= w_dly[0] ? r_in : 8'd0;
      r_grn     <= w_dly[0] ? g_in : 8'd0;
      r_blu     <= w_dly[0] ? b_in : 8'd0;
    end
  end

  assign x            = r_h_cnt;
  assign y            = r_v_cnt;
  assign req          = w_visible;
  assign frame_start  = r_frame_start;
  assign vblank_start = r_vblank_start;
  assign VGA_R        = r_red;
  assign VGA_G        = r_grn;
  assign VGA_B        = r_blu;
  assign VGA_HS       = r_hs;
  assign VGA_VS       = r_vs;
  assign VGA_BLANK_N  = r_blank_n;
  assign VGA_SYNC_N   = 1'b0;
  assign VGA_CLK      = r_phase;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: PIPE_DEPTH=2 and PIPE_DEPTH=0 instances checked every cycle
// against a cycle-count timing model, with random per-pixel colours and random don't-care inputs.
module tb_vga_timing_gen;

  localparam int NT = 8000;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        req;
    logic        clk;
    logic        hs;
    logic        vs;
    logic        bl;
    logic        fs;
    logic        vbs;
    logic [23:0] rgb;
  } exp_t;

  logic clk;
  logic rst_n;

  logic [7:0] r2, g2, b2, r0, g0, b0;
  logic [9:0] x2, y2, x0, y0;
  logic       req2, fs2, vbs2, hs2, vs2, bl2, sn2, vclk2;
  logic       req0, fs0, vbs0, hs0, vs0, bl0, sn0, vclk0;
  logic [7:0] vr2, vg2, vb2, vr0, vg0, vb0;

  logic [23:0] col [NT];
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  vga_timing_gen #(.PIPE_DEPTH(2)) u_dut2 (
    .CLOCK_50(clk), .reset_n(rst_n), .x(x2), .y(y2), .req(req2),
    .frame_start(fs2), .vblank_start(vbs2), .r_in(r2), .g_in(g2), .b_in(b2),
    .VGA_R(vr2), .VGA_G(vg2), .VGA_B(vb2), .VGA_HS(hs2), .VGA_VS(vs2),
    .VGA_BLANK_N(bl2), .VGA_SYNC_N(sn2), .VGA_CLK(vclk2)
  );

  vga_timing_gen #(.PIPE_DEPTH(0)) u_dut0 (
    .CLOCK_50(clk), .reset_n(rst_n), .x(x0), .y(y0), .req(req0),
    .frame_start(fs0), .vblank_start(vbs0), .r_in(r0), .g_in(g0), .b_in(b0),
    .VGA_R(vr0), .VGA_G(vg0), .VGA_B(vb0), .VGA_HS(hs0), .VGA_VS(vs0),
    .VGA_BLANK_N(bl0), .VGA_SYNC_N(sn0), .VGA_CLK(vclk0)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  function automatic logic [23:0] colour(input int m);
    return (m >= 0 && m < NT) ? col[m] : 24'h0;
  endfunction

  // Expected outputs after rising edge c since reset release: tick n = c/2, pins show tick n-d-1.
  function automatic exp_t model(input int c, input int d, input logic in_reset);
    exp_t e;
    int n, m, hm, vm;
    e = '0;
    e.hs = 1'b1;
    e.vs = 1'b1;
    e.req = 1'b1;
    if (in_reset) return e;
    n = c / 2;
    e.x   = 10'(n % 800);
    e.y   = 10'((n / 800) % 525);
    e.req = (n % 800 < 640) && ((n / 800) % 525 < 480);
    e.clk = (c % 2 == 1);
    e.fs  = (c % 2 == 0) && (n > 0) && (n % 420000 == 0);
    e.vbs = (c % 2 == 0) && (n % 420000 == 384000);
    m = n - d - 1;
    if (m >= 0) begin
      hm = m % 800;
      vm = (m / 800) % 525;
      e.hs  = !(hm >= 656 && hm <= 751);
      e.vs  = !(vm >= 490 && vm <= 491);
      e.bl  = (hm < 640) && (vm < 480);
      e.rgb = e.bl ? colour(m) : 24'h0;
    end
    return e;
  endfunction

  task automatic cmp_dut(input string t, input exp_t e, input logic [9:0] ax, input logic [9:0] ay,
                         input logic areq, input logic aclk, input logic ahs, input logic avs,
                         input logic abl, input logic asn, input logic afs, input logic avbs,
                         input logic [23:0] argb);
    check({t, ".x"},            32'(ax),   32'(e.x));
    check({t, ".y"},            32'(ay),   32'(e.y));
    check({t, ".req"},          32'(areq), 32'(e.req));
    check({t, ".vga_clk"},      32'(aclk), 32'(e.clk));
    check({t, ".vga_hs"},       32'(ahs),  32'(e.hs));
    check({t, ".vga_vs"},       32'(avs),  32'(e.vs));
    check({t, ".vga_blank_n"},  32'(abl),  32'(e.bl));
    check({t, ".vga_sync_n"},   32'(asn),  32'd0);
    check({t, ".frame_start"},  32'(afs),  32'(e.fs));
    check({t, ".vblank_start"}, 32'(avbs), 32'(e.vbs));
    check({t, ".rgb"},          32'(argb), 32'(e.rgb));
  endtask

  // Compare process plus renderer model: sample at negedge, then set up colour for the next edge.
  initial begin
    exp_t e2, e0;
    int hs_fall, bl_rise, cn, m2, m0;
    logic prev_hs, prev_bl;
    hs_fall = -1;
    bl_rise = -1;
    prev_hs = 1'b1;
    prev_bl = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cyc = 0;
        e2 = model(0, 2, 1'b1);
        e0 = model(0, 0, 1'b1);
        hs_fall = -1;
        bl_rise = -1;
      end else begin
        cyc++;
        e2 = model(cyc, 2, 1'b0);
        e0 = model(cyc, 0, 1'b0);
      end
      cmp_dut("d2", e2, x2, y2, req2, vclk2, hs2, vs2, bl2, sn2, fs2, vbs2, {vr2, vg2, vb2});
      cmp_dut("d0", e0, x0, y0, req0, vclk0, hs0, vs0, bl0, sn0, fs0, vbs0, {vr0, vg0, vb0});

      if (rst_n) begin
        if (cyc == 2)    check("x_one_after_release", 32'(x2), 32'd1);
        if (cyc == 1317) check("d2_hs_before_fall", 32'(hs2), 32'd1);
        if (cyc == 1318) check("d2_hs_fall_at_656+3", 32'(hs2), 32'd0);
        if (cyc == 1313) check("d0_hs_before_fall", 32'(hs0), 32'd1);
        if (cyc == 1314) check("d0_hs_fall_at_656+1", 32'(hs0), 32'd0);
        if (cyc == 1406) check("d2_rgb_forced_in_hblank", 32'({vr2, vg2, vb2}), 32'd0);
        if (cyc == 8006) check("d2_line5_px0_red", 32'(vr2), 32'd0);
        if (cyc == 8406) check("d2_line5_px200_red", 32'(vr2), 32'd200);
        if (cyc == 8402) check("d0_line5_px200_red", 32'(vr0), 32'd200);

        if (prev_hs && !hs2) begin
          if (hs_fall >= 0) check("hs_period", 32'(cyc - hs_fall), 32'd1600);
          hs_fall = cyc;
        end
        if (!prev_hs && hs2 && hs_fall >= 0) check("hs_low_len", 32'(cyc - hs_fall), 32'd192);
        if (!prev_bl && bl2) bl_rise = cyc;
        if (prev_bl && !bl2 && bl_rise >= 0) check("blank_high_len", 32'(cyc - bl_rise), 32'd1280);
      end
      prev_hs = hs2;
      prev_bl = bl2;

      cn = cyc + 1;
      if (rst_n && (cn % 2 == 0)) begin
        m2 = cn / 2 - 3;
        m0 = cn / 2 - 1;
        {r2, g2, b2} = (m2 >= 0) ? colour(m2) : 24'($urandom);
        {r0, g0, b0} = (m0 >= 0) ? colour(m0) : 24'($urandom);
      end else begin
        {r2, g2, b2} = 24'($urandom);
        {r0, g0, b0} = 24'($urandom);
      end
    end
  end

  initial begin
    exp_t er;
    rst_n = 1'b0;
    {r2, g2, b2} = 24'h0;
    {r0, g0, b0} = 24'h0;
    for (int i = 0; i < NT; i++) begin
      col[i] = 24'($urandom);
      if (i / 800 == 5) col[i][23:16] = 8'(i % 800);
      else if ($urandom_range(0, 7) == 0) col[i] = 24'hFFFFFF;
    end

    repeat (5) @(negedge clk);
    #2 rst_n = 1'b1;

    repeat (601) @(posedge clk);
    #3;
    check("x_before_midline_reset", 32'(x2), 32'd300);
    rst_n = 1'b0;
    #1;
    er = model(0, 2, 1'b1);
    cmp_dut("d2_async", er, x2, y2, req2, vclk2, hs2, vs2, bl2, sn2, fs2, vbs2, {vr2, vg2, vb2});
    er = model(0, 0, 1'b1);
    cmp_dut("d0_async", er, x0, y0, req0, vclk0, hs0, vs0, bl0, sn0, fs0, vbs0, {vr0, vg0, vb0});

    repeat (5) @(negedge clk);
    #2 rst_n = 1'b1;

    repeat (12000) @(posedge clk);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
